// File: rtl/csr_access_unit.sv
// Zicsr execution unit: read-modify-write of one CSR per instruction, with
// valid/ready handshakes toward decode and writeback.
module csr_access_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_funct3_i,
  input  logic [CSR_AW-1:0] req_csr_addr_i,
  input  logic [XLEN-1:0]   req_rs1_data_i,
  input  logic [4:0]        req_rs1_idx_i,
  input  logic [4:0]        req_rd_idx_i,
  output logic              csr_read_enable_o,
  output logic              csr_write_enable_o,
  output logic [CSR_AW-1:0] csr_address_o,
  output logic [XLEN-1:0]   csr_write_data_o,
  input  logic [XLEN-1:0]   csr_read_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [4:0]        rsp_rd_idx_o,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_illegal_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_MODIFY = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [CSR_AW-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic [4:0]        rd_idx_q, rd_idx_d;
  logic              wreq_q, wreq_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   old_q, old_d;

  logic              req_wreq_c;
  logic              req_addr_ok_c;
  logic              req_illegal_c;
  logic [XLEN-1:0]   new_val_c;

  // Decode legality of the incoming request at capture time
  always_comb begin
    req_wreq_c    = (req_funct3_i[1:0] == 2'b01) || (req_rs1_idx_i != 5'd0);
    req_addr_ok_c = 1'b0;
    case (req_csr_addr_i)
      CSR_AW'(12'h300), CSR_AW'(12'h301), CSR_AW'(12'h304), CSR_AW'(12'h305),
      CSR_AW'(12'h340), CSR_AW'(12'h341), CSR_AW'(12'h342), CSR_AW'(12'h344):
        req_addr_ok_c = 1'b1;
      default: req_addr_ok_c = 1'b0;
    endcase
    req_illegal_c = (req_funct3_i[1:0] == 2'b00) || !req_addr_ok_c ||
                    ((req_csr_addr_i[CSR_AW-1 -: 2] == 2'b11) && req_wreq_c);
  end

  // New CSR value from the old value arriving from the register file
  always_comb begin
    new_val_c = operand_q;
    case (funct3_q[1:0])
      2'b10:   new_val_c = csr_read_data_i | operand_q;
      2'b11:   new_val_c = csr_read_data_i & ~operand_q;
      default: new_val_c = operand_q;
    endcase
  end

  // Next-state and capture logic
  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    operand_d = operand_q;
    rd_idx_d  = rd_idx_q;
    wreq_d    = wreq_q;
    illegal_d = illegal_q;
    old_d     = old_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          funct3_d  = req_funct3_i;
          addr_d    = req_csr_addr_i;
          operand_d = req_funct3_i[2] ? XLEN'(req_rs1_idx_i) : req_rs1_data_i;
          rd_idx_d  = req_rd_idx_i;
          wreq_d    = req_wreq_c;
          illegal_d = req_illegal_c;
          state_d   = ST_READ;
        end
      end
      ST_READ:   state_d = ST_MODIFY;
      ST_MODIFY: begin
        old_d   = csr_read_data_i;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-operand registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      operand_q <= '0;
      rd_idx_q  <= 5'd0;
      wreq_q    <= 1'b0;
      illegal_q <= 1'b0;
      old_q     <= '0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      rd_idx_q  <= rd_idx_d;
      wreq_q    <= wreq_d;
      illegal_q <= illegal_d;
      old_q     <= old_d;
    end
  end

  // Outputs decoded from the state register; write data depends on the
  // same-cycle read data, so the register-file port cannot be retimed
  always_comb begin
    req_ready_o        = (state_q == ST_IDLE);
    csr_read_enable_o  = (state_q == ST_READ);
    csr_write_enable_o = (state_q == ST_MODIFY) && wreq_q && !illegal_q;
    csr_address_o      = ((state_q == ST_READ) || (state_q == ST_MODIFY)) ? addr_q : '0;
    csr_write_data_o   = (state_q == ST_MODIFY) ? new_val_c : '0;
    rsp_valid_o        = (state_q == ST_RESP);
    rsp_illegal_o      = (state_q == ST_RESP) && illegal_q;
    rsp_data_o         = ((state_q == ST_RESP) && !illegal_q) ? old_q : '0;
    rsp_rd_idx_o       = ((state_q == ST_RESP) && !illegal_q) ? rd_idx_q : 5'd0;
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a behavioural CSR register file.
module tb_csr_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [11:0] req_csr_addr_i;
  logic [31:0] req_rs1_data_i;
  logic [4:0]  req_rs1_idx_i;
  logic [4:0]  req_rd_idx_i;
  logic        csr_read_enable_o;
  logic        csr_write_enable_o;
  logic [11:0] csr_address_o;
  logic [31:0] csr_write_data_o;
  logic [31:0] csr_read_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [4:0]  rsp_rd_idx_o;
  logic [31:0] rsp_data_o;
  logic        rsp_illegal_o;

  int total = 0;
  int bad   = 0;

  csr_access_unit dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_funct3_i       (req_funct3_i),
    .req_csr_addr_i     (req_csr_addr_i),
    .req_rs1_data_i     (req_rs1_data_i),
    .req_rs1_idx_i      (req_rs1_idx_i),
    .req_rd_idx_i       (req_rd_idx_i),
    .csr_read_enable_o  (csr_read_enable_o),
    .csr_write_enable_o (csr_write_enable_o),
    .csr_address_o      (csr_address_o),
    .csr_write_data_o   (csr_write_data_o),
    .csr_read_data_i    (csr_read_data_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_rd_idx_o       (rsp_rd_idx_o),
    .rsp_data_o         (rsp_data_o),
    .rsp_illegal_o      (rsp_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // CSR register file model: registered read, write on enable, write log
  logic [31:0] mem [0:4095];
  int          wr_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [11:0] last_waddr = '0;

  always @(posedge clk_i) begin
    if (csr_read_enable_o) csr_read_data_i <= mem[csr_address_o];
    if (csr_write_enable_o) begin
      mem[csr_address_o] <= csr_write_data_o;
      wr_cnt             <= wr_cnt + 1;
      last_wdata         <= csr_write_data_o;
      last_waddr         <= csr_address_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response, sample it
  task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                        input logic [4:0] idx, input logic [4:0] rd,
                        output logic [31:0] o_data, output logic [4:0] o_rd,
                        output logic o_ill, output int lat);
    @(negedge clk_i);
    req_valid_i    = 1'b1;
    req_funct3_i   = f3;
    req_csr_addr_i = a;
    req_rs1_data_i = d;
    req_rs1_idx_i  = idx;
    req_rd_idx_i   = rd;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    o_data = rsp_data_o;
    o_rd   = rsp_rd_idx_o;
    o_ill  = rsp_illegal_o;
  endtask

  logic [31:0] d;
  logic [4:0]  rd;
  logic        ill;
  int          lat;
  int          w0;

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_funct3_i = 3'd0; req_csr_addr_i = 12'd0;
    req_rs1_data_i = 32'd0; req_rs1_idx_i = 5'd0; req_rd_idx_i = 5'd0; rsp_ready_i = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rd_en", 32'(csr_read_enable_o), 32'd0);
    check("rst_wr_en", 32'(csr_write_enable_o), 32'd0);
    check("rst_addr", 32'(csr_address_o), 32'd0);
    check("rst_rsp_data", rsp_data_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Preload CSRs through the unit itself
    do_req(3'b001, 12'h340, 32'h1111_2222, 5'd1, 5'd1, d, rd, ill, lat);
    do_req(3'b001, 12'h300, 32'h0000_0008, 5'd1, 5'd1, d, rd, ill, lat);
    do_req(3'b001, 12'h305, 32'h0000_0100, 5'd1, 5'd1, d, rd, ill, lat);
    do_req(3'b001, 12'h341, 32'hCAFE_0000, 5'd1, 5'd1, d, rd, ill, lat);
    check("preload_writes", 32'(wr_cnt), 32'd4);

    // T1 CSRRW
    w0 = wr_cnt;
    do_req(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd3, 5'd5, d, rd, ill, lat);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_old", d, 32'h1111_2222);
    check("t1_rd", 32'(rd), 32'd5);
    check("t1_illegal", 32'(ill), 32'd0);
    check("t1_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("t1_wdata", last_wdata, 32'hDEAD_BEEF);
    check("t1_waddr", 32'(last_waddr), 32'h340);
    w0 = wr_cnt;
    do_req(3'b010, 12'h340, 32'hFFFF_FFFF, 5'd0, 5'd6, d, rd, ill, lat);
    check("t1_readback", d, 32'hDEAD_BEEF);
    check("t1_readback_nowr", 32'(wr_cnt - w0), 32'd0);

    // T2 CSRRSI then CSRRC
    w0 = wr_cnt;
    do_req(3'b110, 12'h300, 32'hFFFF_FFFF, 5'd3, 5'd2, d, rd, ill, lat);
    check("t2_rsi_old", d, 32'h0000_0008);
    check("t2_rsi_wdata", last_wdata, 32'h0000_000B);
    check("t2_rsi_wr_count", 32'(wr_cnt - w0), 32'd1);
    do_req(3'b011, 12'h300, 32'h0000_0009, 5'd7, 5'd3, d, rd, ill, lat);
    check("t2_rc_old", d, 32'h0000_000B);
    check("t2_rc_wdata", last_wdata, 32'h0000_0002);

    // T3 CSRRS with rs1 index 0 performs no write
    w0 = wr_cnt;
    do_req(3'b010, 12'h305, 32'hFFFF_FFFF, 5'd0, 5'd4, d, rd, ill, lat);
    check("t3_old", d, 32'h0000_0100);
    check("t3_no_write", 32'(wr_cnt - w0), 32'd0);

    // T4 illegal address and illegal funct3
    w0 = wr_cnt;
    do_req(3'b001, 12'h7C0, 32'h1234_5678, 5'd1, 5'd8, d, rd, ill, lat);
    check("t4_addr_illegal", 32'(ill), 32'd1);
    check("t4_addr_data", d, 32'd0);
    check("t4_addr_rd", 32'(rd), 32'd0);
    do_req(3'b100, 12'h340, 32'h1234_5678, 5'd1, 5'd8, d, rd, ill, lat);
    check("t4_f3_illegal", 32'(ill), 32'd1);
    check("t4_f3_data", d, 32'd0);
    check("t4_no_write", 32'(wr_cnt - w0), 32'd0);
    do_req(3'b010, 12'h340, 32'd0, 5'd0, 5'd9, d, rd, ill, lat);
    check("t4_mscratch_kept", d, 32'hDEAD_BEEF);

    // T5 backpressure with an intruding request
    rsp_ready_i = 1'b0;
    w0 = wr_cnt;
    do_req(3'b010, 12'h340, 32'd0, 5'd0, 5'd9, d, rd, ill, lat);
    check("t5_old", d, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_valid_i = 1'b1; req_funct3_i = 3'b001; req_csr_addr_i = 12'h341;
        req_rs1_data_i = 32'h0000_0055; req_rs1_idx_i = 5'd2; req_rd_idx_i = 5'd3;
      end else begin
        req_valid_i = 1'b0;
      end
      @(negedge clk_i);
      check("t5_valid_held", 32'(rsp_valid_o), 32'd1);
      check("t5_data_held", rsp_data_o, 32'hDEAD_BEEF);
      check("t5_rd_held", 32'(rsp_rd_idx_o), 32'd9);
      check("t5_not_ready", 32'(req_ready_o), 32'd0);
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("t5_released", 32'(rsp_valid_o), 32'd0);
    check("t5_ready_again", 32'(req_ready_o), 32'd1);
    check("t5_ignored_req", 32'(wr_cnt - w0), 32'd0);

    // T6 reset during MODIFY drops the pending write
    w0 = wr_cnt;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_funct3_i = 3'b001; req_csr_addr_i = 12'h341;
    req_rs1_data_i = 32'h1234_5678; req_rs1_idx_i = 5'd4; req_rd_idx_i = 5'd4;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("t6_modify_wen", 32'(csr_write_enable_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_wen_dropped", 32'(csr_write_enable_o), 32'd0);
    check("t6_addr_zero", 32'(csr_address_o), 32'd0);
    check("t6_wdata_zero", csr_write_data_o, 32'd0);
    check("t6_ready", 32'(req_ready_o), 32'd1);
    check("t6_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("t6_no_write", 32'(wr_cnt - w0), 32'd0);
    do_req(3'b010, 12'h341, 32'd0, 5'd0, 5'd1, d, rd, ill, lat);
    check("t6_mepc_kept", d, 32'hCAFE_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
